bcd_7seg_scan: RTL and testbench

Multiplexed 3-digit seven-segment driver sitting directly downstream of the binary-to-BCD converter. Captures the units/tens/hundreds BCD digits on the rising edge of the converter's `DONE`, acknowledges the capture, and time-multiplexes the digits onto a shared segment bus with per-digit anode enables, a prescaled refresh rate and an inter-digit blanking cycle.

---
 rtl/bcd_7seg_scan.sv | 176 +++++++++++++++++
 tb/tb_bcd_7seg_scan.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_7seg_scan.sv
// ============================================================================
// Module   : bcd_7seg_scan
// Brief    : Multiplexed 3-digit seven-segment driver. Captures BCD digits on
//            the rising edge of the converter DONE level, pulses ACK, and scans
//            UND -> DEC -> CEN with a DIV-cycle lit slot and one blank cycle
//            between digits.
// Options  : define BCD_LEADING_ZERO_BLANK_EN to blank leading zeros
//            (CEN when zero, DEC when CEN and DEC are both zero).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_7seg_scan #(
  parameter int DIV        = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_DONE,
  input  logic [3:0] in_UND,
  input  logic [3:0] in_DEC,
  input  logic [3:0] in_CEN,
  output logic [6:0] out_SEG,
  output logic [2:0] out_AN,
  output logic       out_ACK
);

  localparam int            CW       = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SCAN_UND = 3'd1;
  localparam logic [2:0] SCAN_DEC = 3'd2;
  localparam logic [2:0] SCAN_CEN = 3'd3;
  localparam logic [2:0] BLANK    = 3'd4;

  logic          done_q;
  logic          ack;
  logic [3:0]    und;
  logic [3:0]    dec;
  logic [3:0]    cen;
  logic [2:0]    state;
  logic [2:0]    next_scan;
  logic [CW-1:0] cnt;
  logic          capture;

  logic [6:0]    seg_l;
  logic [2:0]    an_l;
  logic          sup_dec;
  logic          sup_cen;

  assign capture = in_DONE & ~done_q;

  // Standard gfedcba patterns; non-decimal codes show a dash.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b0111111;
      4'd1:    seg_of = 7'b0000110;
      4'd2:    seg_of = 7'b1011011;
      4'd3:    seg_of = 7'b1001111;
      4'd4:    seg_of = 7'b1100110;
      4'd5:    seg_of = 7'b1101101;
      4'd6:    seg_of = 7'b1111101;
      4'd7:    seg_of = 7'b0000111;
      4'd8:    seg_of = 7'b1111111;
      4'd9:    seg_of = 7'b1101111;
      default: seg_of = 7'b1000000;
    endcase
  endfunction

  // DONE edge detection, digit capture and the one-cycle acknowledge.
  // done_q follows DONE even in reset so a level held across reset is not
  // mistaken for a fresh conversion.
  always_ff @(posedge clk) begin
    done_q <= in_DONE;
    if (rst) begin
      ack <= 1'b0;
      und <= 4'd0;
      dec <= 4'd0;
      cen <= 4'd0;
    end else begin
      ack <= capture;
      if (capture) begin
        und <= in_UND;
        dec <= in_DEC;
        cen <= in_CEN;
      end
    end
  end

  // Scan sequencer: the registered ACK of the first capture starts scanning;
  // a late capture never disturbs the slot position or the refresh counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      next_scan <= SCAN_UND;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ack) begin
            state <= SCAN_UND;
            cnt   <= '0;
          end
        end
        SCAN_UND, SCAN_DEC, SCAN_CEN: begin
          if (cnt == CNT_LAST) begin
            state <= BLANK;
            case (state)
              SCAN_UND: next_scan <= SCAN_DEC;
              SCAN_DEC: next_scan <= SCAN_CEN;
              default:  next_scan <= SCAN_UND;
            endcase
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BLANK: begin
          state <= next_scan;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  assign sup_cen = (cen == 4'd0);
  assign sup_dec = (cen == 4'd0) && (dec == 4'd0);
`else
  assign sup_cen = 1'b0;
  assign sup_dec = 1'b0;
`endif

  // Logical (active-high) segment and anode values from registered state only.
  always_comb begin
    seg_l = 7'b0000000;
    an_l  = 3'b000;
    case (state)
      SCAN_UND: begin
        an_l  = 3'b001;
        seg_l = seg_of(und);
      end
      SCAN_DEC: begin
        an_l  = 3'b010;
        seg_l = sup_dec ? 7'b0000000 : seg_of(dec);
      end
      SCAN_CEN: begin
        an_l  = 3'b100;
        seg_l = sup_cen ? 7'b0000000 : seg_of(cen);
      end
      default: begin
        seg_l = 7'b0000000;
        an_l  = 3'b000;
      end
    endcase
  end

  generate
    if (ACTIVE_LOW) begin : g_active_low
      assign out_SEG = ~seg_l;
      assign out_AN  = ~an_l;
    end else begin : g_active_high
      assign out_SEG = seg_l;
      assign out_AN  = an_l;
    end
  endgenerate

  assign out_ACK = ack;

endmodule

`default_nettype wire

// File: tb/tb_bcd_7seg_scan.sv
`default_nettype none

module tb_bcd_7seg_scan;

  localparam int D     = 4;
  localparam int SLOT  = D + 1;
  localparam int FRAME = 3 * SLOT;

  logic       clk;
  logic       rst;
  logic       in_DONE;
  logic [3:0] in_UND;
  logic [3:0] in_DEC;
  logic [3:0] in_CEN;
  logic [6:0] out_SEG;
  logic [2:0] out_AN;
  logic       out_ACK;

  int tests;
  int fails;

  bcd_7seg_scan #(.DIV(D), .ACTIVE_LOW(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_DONE (in_DONE),
    .in_UND  (in_UND),
    .in_DEC  (in_DEC),
    .in_CEN  (in_CEN),
    .out_SEG (out_SEG),
    .out_AN  (out_AN),
    .out_ACK (out_ACK)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference ----------------
  logic [6:0] pat [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic       m_done_q;
  logic [3:0] m_dig [0:2];
  logic       m_ack;
  bit         m_started;
  int         m_t;
  logic [6:0] exp_seg;
  logic [2:0] exp_an;
  logic       exp_ack;

  function automatic int m_slot();
    if (!m_started || (m_t % FRAME) % SLOT == D) return -1;
    return (m_t % FRAME) / SLOT;
  endfunction

  function automatic int m_within();
    return (m_t % FRAME) % SLOT;
  endfunction

  // Drives one cycle, advances the model on the clock edge, then waits 1 unit.
  task automatic step(input logic r, input logic d,
                      input logic [3:0] u, input logic [3:0] t, input logic [3:0] c);
    int         s;
    logic [6:0] sg;
    logic [2:0] an;
    bit         cap;
    @(negedge clk);
    rst = r; in_DONE = d; in_UND = u; in_DEC = t; in_CEN = c;
    @(posedge clk);
    if (r) begin
      m_done_q = d; m_ack = 1'b0; m_started = 0; m_t = 0;
      m_dig[0] = 4'd0; m_dig[1] = 4'd0; m_dig[2] = 4'd0;
    end else begin
      cap = d && !m_done_q;
      if (m_started) m_t++;
      else if (m_ack) begin m_started = 1; m_t = 0; end
      if (cap) begin m_dig[0] = u; m_dig[1] = t; m_dig[2] = c; end
      m_done_q = d;
      m_ack    = cap;
    end
    s  = m_slot();
    sg = 7'h00;
    an = 3'b000;
    if (s >= 0) begin
      an = 3'(1 << s);
      sg = (m_dig[s] > 4'd9) ? 7'h40 : pat[m_dig[s]];
`ifdef BCD_LEADING_ZERO_BLANK_EN
      if (s == 2 && m_dig[2] == 4'd0) sg = 7'h00;
      if (s == 1 && m_dig[2] == 4'd0 && m_dig[1] == 4'd0) sg = 7'h00;
`endif
    end
    exp_seg = ~sg;
    exp_an  = ~an;
    exp_ack = m_ack;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
      tests++; if (out_SEG !== 7'h7F) begin fails++; $display("FAIL reset_seg got=%b want=1111111", out_SEG); end
      tests++; if (out_AN !== 3'b111) begin fails++; $display("FAIL reset_an got=%b want=111", out_AN); end
      tests++; if (out_ACK !== 1'b0) begin fails++; $display("FAIL reset_ack got=%b want=0", out_ACK); end
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
      tests++; if (out_SEG !== exp_seg) begin fails++; $display("FAIL idle_seg cyc=%0d got=%b want=%b", i, out_SEG, exp_seg); end
      tests++; if (out_AN !== exp_an) begin fails++; $display("FAIL idle_an cyc=%0d got=%b want=%b", i, out_AN, exp_an); end
      tests++; if (out_ACK !== exp_ack) begin fails++; $display("FAIL idle_ack cyc=%0d got=%b want=%b", i, out_ACK, exp_ack); end
    end
  endtask

  task automatic test_capture_scan();
    int acks;
    acks = 0;
    for (int i = 0; i < 2 + 2 * FRAME + 3; i++) begin
      step(1'b0, 1'b1, 4'd1, 4'd2, 4'd3);
      if (out_ACK === 1'b1) acks++;
      tests++; if (out_SEG !== exp_seg) begin fails++; $display("FAIL scan_seg cyc=%0d got=%b want=%b", i, out_SEG, exp_seg); end
      tests++; if (out_AN !== exp_an) begin fails++; $display("FAIL scan_an cyc=%0d got=%b want=%b", i, out_AN, exp_an); end
      tests++; if (out_ACK !== exp_ack) begin fails++; $display("FAIL scan_ack cyc=%0d got=%b want=%b", i, out_ACK, exp_ack); end
      if (i == 2) begin
        tests++; if (out_AN !== 3'b110 || out_SEG !== ~7'b0000110)
          begin fails++; $display("FAIL first_digit got an=%b seg=%b want an=110 seg=1111001", out_AN, out_SEG); end
      end
    end
    tests++; if (acks != 1) begin fails++; $display("FAIL ack_count got=%0d want=1", acks); end
  endtask

  task automatic test_mid_scan_update();
    int guard;
    guard = 0;
    while (!(m_slot() == 1 && m_within() == 0) && guard < 4 * FRAME) begin
      step(1'b0, 1'b1, 4'd1, 4'd2, 4'd3);
      guard++;
    end
    tests++; if (guard >= 4 * FRAME) begin fails++; $display("FAIL mid_timeout got=%0d want<%0d", guard, 4 * FRAME); end
    step(1'b0, 1'b0, 4'd1, 4'd7, 4'd3);
    tests++; if (out_SEG !== exp_seg) begin fails++; $display("FAIL mid_drop_seg got=%b want=%b", out_SEG, exp_seg); end
    step(1'b0, 1'b1, 4'd1, 4'd7, 4'd3);
    tests++; if (out_SEG !== ~7'b0000111 || out_AN !== 3'b101)
      begin fails++; $display("FAIL mid_update got seg=%b an=%b want seg=1111000 an=101", out_SEG, out_AN); end
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 1'b1, 4'd1, 4'd7, 4'd3);
      tests++; if (out_SEG !== exp_seg) begin fails++; $display("FAIL mid_seg cyc=%0d got=%b want=%b", i, out_SEG, exp_seg); end
      tests++; if (out_AN !== exp_an) begin fails++; $display("FAIL mid_an cyc=%0d got=%b want=%b", i, out_AN, exp_an); end
      tests++; if (out_ACK !== exp_ack) begin fails++; $display("FAIL mid_ack cyc=%0d got=%b want=%b", i, out_ACK, exp_ack); end
    end
  endtask

  task automatic test_invalid_digit();
    step(1'b0, 1'b0, 4'd12, 4'd2, 4'd3);
    for (int i = 0; i < FRAME + 2; i++) begin
      step(1'b0, 1'b1, 4'd12, 4'd2, 4'd3);
      tests++; if (out_SEG !== exp_seg) begin fails++; $display("FAIL inv_seg cyc=%0d got=%b want=%b", i, out_SEG, exp_seg); end
      tests++; if (out_AN !== exp_an) begin fails++; $display("FAIL inv_an cyc=%0d got=%b want=%b", i, out_AN, exp_an); end
      if (m_slot() == 0) begin
        tests++; if (out_SEG !== ~7'b1000000) begin fails++; $display("FAIL dash got=%b want=0111111", out_SEG); end
      end
    end
  endtask

  task automatic test_zero_blank();
    step(1'b0, 1'b0, 4'd5, 4'd0, 4'd0);
    for (int i = 0; i < FRAME + 2; i++) begin
      step(1'b0, 1'b1, 4'd5, 4'd0, 4'd0);
      tests++; if (out_SEG !== exp_seg) begin fails++; $display("FAIL lz_seg cyc=%0d got=%b want=%b", i, out_SEG, exp_seg); end
      tests++; if (out_AN !== exp_an) begin fails++; $display("FAIL lz_an cyc=%0d got=%b want=%b", i, out_AN, exp_an); end
      if (m_slot() == 0) begin
        tests++; if (out_SEG !== ~7'b1101101) begin fails++; $display("FAIL five got=%b want=0010010", out_SEG); end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 4'd9, 4'd8, 4'd7);
    tests++; if (out_AN !== 3'b111 || out_SEG !== 7'h7F || out_ACK !== 1'b0)
      begin fails++; $display("FAIL rst_mid got an=%b seg=%b ack=%b want an=111 seg=1111111 ack=0", out_AN, out_SEG, out_ACK); end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 4'd9, 4'd8, 4'd7);
      tests++; if (out_AN !== 3'b111 || out_ACK !== 1'b0)
        begin fails++; $display("FAIL no_recap cyc=%0d got an=%b ack=%b want an=111 ack=0", i, out_AN, out_ACK); end
    end
    step(1'b0, 1'b0, 4'd9, 4'd8, 4'd7);
    step(1'b0, 1'b1, 4'd9, 4'd8, 4'd7);
    tests++; if (out_ACK !== 1'b1) begin fails++; $display("FAIL recap_ack got=%b want=1", out_ACK); end
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 1'b1, 4'd9, 4'd8, 4'd7);
      tests++; if (out_SEG !== exp_seg) begin fails++; $display("FAIL recap_seg cyc=%0d got=%b want=%b", i, out_SEG, exp_seg); end
      tests++; if (out_AN !== exp_an) begin fails++; $display("FAIL recap_an cyc=%0d got=%b want=%b", i, out_AN, exp_an); end
    end
  endtask

  task automatic test_random();
    logic d;
    logic r;
    d = in_DONE;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) d = ~d;
      r = ($urandom_range(0, 149) == 0);
      step(r, d, 4'($urandom), 4'($urandom), 4'($urandom_range(0, 2)));
      tests++; if (out_SEG !== exp_seg) begin fails++; $display("FAIL rnd_seg cyc=%0d got=%b want=%b", i, out_SEG, exp_seg); end
      tests++; if (out_AN !== exp_an) begin fails++; $display("FAIL rnd_an cyc=%0d got=%b want=%b", i, out_AN, exp_an); end
      tests++; if (out_ACK !== exp_ack) begin fails++; $display("FAIL rnd_ack cyc=%0d got=%b want=%b", i, out_ACK, exp_ack); end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; in_DONE = 1'b0; in_UND = 4'd0; in_DEC = 4'd0; in_CEN = 4'd0;
    m_done_q = 1'b0; m_ack = 1'b0; m_started = 0; m_t = 0;
    m_dig[0] = 4'd0; m_dig[1] = 4'd0; m_dig[2] = 4'd0;
    exp_seg = 7'h7F; exp_an = 3'b111; exp_ack = 1'b0;
    test_reset();
    test_capture_scan();
    test_mid_scan_update();
    test_invalid_digit();
    test_zero_blank();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
